alu_operand_collector: RTL

- Upstream neighbour of the ALU.
- Accepts one decoded ALU instruction at a time: opcode, up to three source register indices and a destination index.
- Fetches the required source operands through a single synchronous register-file read port, one read per cycle.
- Presents opcode, operand1/2/3 and destination to the ALU stage over a valid/ready handshake.

---
 rtl/alu_operand_collector.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_operand_collector.sv
// ALU operand collector: takes one decoded instruction and fetches its sources over one RF read port.
// Optional macro ALU_OC_WB_BYPASS_EN adds same-cycle writeback forwarding into operand capture.
package warp_pkg;
  parameter int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_MUL  = 4'd1,
    OP_MAX  = 4'd2,
    OP_RELU = 4'd3,
    OP_FMA  = 4'd4
  } alu_opcode_e;
endpackage

module alu_operand_collector
  import warp_pkg::*;
#(
  parameter int DATA_WIDTH = warp_pkg::DATA_WIDTH,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  alu_opcode_e           in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rs3,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  rf_rd_en,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
`ifdef ALU_OC_WB_BYPASS_EN
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output alu_opcode_e           out_opcode,
  output logic [DATA_WIDTH-1:0] out_operand1,
  output logic [DATA_WIDTH-1:0] out_operand2,
  output logic [DATA_WIDTH-1:0] out_operand3,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, ISSUE} state_e;

  function automatic logic [1:0] op_count(input alu_opcode_e op);
    case (op)
      OP_RELU:                return 2'd1;
      OP_ADD, OP_MUL, OP_MAX: return 2'd2;
      OP_FMA:                 return 2'd3;
      default:                return 2'd0;
    endcase
  endfunction

  state_e                         state_q, state_d;
  logic [1:0]                     idx_q, n_q, cap_idx_q;
  logic                           cap_vld_q;
  logic [REG_ADDR_W-1:0]          cap_addr_q;
  alu_opcode_e                    op_q;
  logic [2:0][REG_ADDR_W-1:0]     rs_q;
  logic [REG_ADDR_W-1:0]          rd_q;
  logic [2:0][DATA_WIDTH-1:0]     opnd_q;
  logic [DATA_WIDTH-1:0]          cap_data;
  logic [1:0]                     n_in;
  logic                           accept;

  assign n_in     = op_count(in_opcode);
  assign in_ready = (state_q == IDLE) || (state_q == ISSUE && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

`ifdef ALU_OC_WB_BYPASS_EN
  // A write landing in the capture cycle is newer than what the RF returned.
  assign cap_data = (wb_valid && wb_addr == cap_addr_q) ? wb_data : rf_rd_data;
`else
  assign cap_data = rf_rd_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE:
        if (accept) state_d = (n_in == 2'd0) ? ISSUE : FETCH;
      FETCH: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = rs_q[idx_q];
        if (idx_q == n_q - 2'd1) state_d = CAPTURE;
      end
      CAPTURE: state_d = ISSUE;
      ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (accept) state_d = (n_in == 2'd0) ? ISSUE : FETCH;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data returns one cycle after the strobe; cap_* remembers which slot it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      n_q        <= '0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= '0;
      cap_addr_q <= '0;
      op_q       <= OP_ADD;
      rs_q       <= '0;
      rd_q       <= '0;
      opnd_q     <= '0;
    end else begin
      cap_vld_q  <= rf_rd_en;
      cap_idx_q  <= idx_q;
      cap_addr_q <= rf_rd_addr;
      if (cap_vld_q) opnd_q[cap_idx_q] <= cap_data;
      if (accept) begin
        op_q   <= in_opcode;
        rs_q   <= {in_rs3, in_rs2, in_rs1};
        rd_q   <= in_rd;
        n_q    <= n_in;
        idx_q  <= '0;
        opnd_q <= '0;
      end else if (rf_rd_en) begin
        idx_q  <= idx_q + 2'd1;
      end
    end
  end

  assign out_opcode   = op_q;
  assign out_operand1 = opnd_q[0];
  assign out_operand2 = opnd_q[1];
  assign out_operand3 = opnd_q[2];
  assign out_rd       = rd_q;

endmodule
